// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg
// Shared types and helpers for the buffered index-to-one-hot decoder.
//   IDX_W          : default index width (vector width 2**IDX_W)
//   STAT_W         : width of each statistics counter
//   entry_t        : queued code {nz, idx}
//   onehot_decode  : entry -> one-hot vector (all zero when nz=0)
package onehot_dec_pkg;

  localparam int IDX_W  = 2;
  localparam int STAT_W = 8;

  typedef struct packed {
    logic             nz;
    logic [IDX_W-1:0] idx;
  } entry_t;

  function automatic logic [2**IDX_W-1:0] onehot_decode(input entry_t e);
    logic [2**IDX_W-1:0] v;
    v = '0;
    // idx is don't-care when nz=0, so it is only looked at under nz
    if (e.nz) v[e.idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec_fifo.sv
// onehot_dec_fifo
// Generic pointer/level FIFO with valid/ready on both sides.
// in_ready and out_valid are derived only from the registered level, so
// there is no combinational path from out_ready to in_ready; a full FIFO
// therefore refuses a push even in a cycle where it is popped.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : write handshake, in_data written on accept
//   out_valid/out_ready   : read handshake, out_data is the head entry
//   level                 : current occupancy (0..DEPTH)
module onehot_dec_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Storage is intentionally not reset; entries are only visible once
  // level says they were written.
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic             push;
  logic             pop;

  assign in_ready  = (level_reg != LVL_W'(DEPTH));
  assign out_valid = (level_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr_reg];
  assign level     = level_reg;

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/onehot_decoder_buf.sv
// onehot_decoder_buf
// Buffered index-to-one-hot decoder. Codes (in_idx, in_nz) are queued in a
// small FIFO; the head entry is decoded combinationally into out_d.
// Optional feature macro: ONEHOT_DEC_STATS_EN adds per-line saturating pop
// counters (hit_cnt) and a counter of popped nz=0 entries (zero_cnt).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : code input handshake
//   in_idx, in_nz       : encoded line index and nonzero flag
//   out_valid/out_ready : decoded output handshake
//   out_d               : one-hot vector of the head entry, 0 when empty
//   level               : FIFO occupancy
//   hit_cnt, zero_cnt   : statistics (only with ONEHOT_DEC_STATS_EN)
module onehot_decoder_buf #(
  parameter int IDX_W = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic                     in_nz,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2**IDX_W-1:0]      out_d,
  output logic [$clog2(DEPTH):0]   level
`ifdef ONEHOT_DEC_STATS_EN
  ,
  output logic [8*(2**IDX_W)-1:0]  hit_cnt,
  output logic [7:0]               zero_cnt
`endif
);

  import onehot_dec_pkg::*;

  localparam int LINES = 2**IDX_W;

  logic [IDX_W:0]       head;
  logic                 head_nz;
  logic [IDX_W-1:0]     head_idx;
  logic [LINES-1:0]     dec_raw;

  onehot_dec_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_nz, in_idx}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .level     (level)
  );

  assign head_nz  = head[IDX_W];
  assign head_idx = head[IDX_W-1:0];

  // The package entry type is fixed at the package index width; other
  // widths fall back to an equivalent per-line compare.
  generate
    if (IDX_W == onehot_dec_pkg::IDX_W) begin : g_pkg_dec
      entry_t head_e;
      assign head_e  = head;
      assign dec_raw = onehot_decode(head_e);
    end else begin : g_gen_dec
      for (genvar gi = 0; gi < LINES; gi++) begin : g_line
        assign dec_raw[gi] = head_nz && (head_idx == IDX_W'(gi));
      end
    end
  endgenerate

  // Storage is unreset, so the empty case must mask whatever the head
  // slot holds.
  assign out_d = out_valid ? dec_raw : '0;

`ifdef ONEHOT_DEC_STATS_EN
  logic pop;
  logic [STAT_W-1:0] zero_cnt_reg;

  assign pop = out_valid && out_ready;

  // out_d is already zero for nz=0 entries, so out_d[gi] on a pop is
  // exactly "this line was popped".
  for (genvar gi = 0; gi < LINES; gi++) begin : g_hit
    logic [STAT_W-1:0] hit_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hit_cnt_reg <= '0;
      end else if (pop && out_d[gi] && (hit_cnt_reg != '1)) begin
        hit_cnt_reg <= hit_cnt_reg + STAT_W'(1);
      end
    end
    assign hit_cnt[8*gi +: 8] = hit_cnt_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_reg <= '0;
    end else if (pop && !head_nz && (zero_cnt_reg != '1)) begin
      zero_cnt_reg <= zero_cnt_reg + STAT_W'(1);
    end
  end

  assign zero_cnt = zero_cnt_reg;
`endif

endmodule

// File: doc/onehot_decoder_buf.md
# onehot_decoder_buf

Buffered index-to-one-hot decoder: the receive end of the priority-encoder interface. It accepts (index, nonzero) codes over a valid/ready handshake, queues them in a small FIFO, and presents the reconstructed one-hot vector downstream over a second valid/ready handshake. It sits after a priority encoder stage, or after any link carrying encoded request lines, and turns the codes back into line-level strobes.

## Interface
- IDX_W, 2: index width; output vector width is 2**IDX_W.
- DEPTH, 4: FIFO entries; power of two, at least 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  code present on in_idx/in_nz.
- in_ready  out  1  FIFO can accept a code this cycle.
- in_idx  in  IDX_W  encoded line index; the encoder's Y.
- in_nz  in  1  nonzero flag; the encoder's valid. 0 means "no line active".
- out_valid  out  1  head entry available.
- out_ready  in  1  downstream consumes the head entry.
- out_d  out  2**IDX_W  decoded vector of the head entry.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_nz, in_idx} at wr_ptr; wr_ptr increments.
- Pop: out_valid && out_ready at a rising edge advances rd_ptr.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- in_ready = (level != DEPTH). It is registered-state only; there is no combinational path from out_ready. A full FIFO does not accept a push in the same cycle as a pop.
- out_valid = (level != 0).
- Decode of the head entry:
  - nz=1: out_d has exactly bit[idx] set, all others 0.
  - nz=0: out_d = 0. This is a legal entry, queued and handshaken like any other.
- When out_valid=0, out_d is forced to 0. It is never X and never stale data.
- in_idx is treated as X-free only when in_nz=1. When in_nz=0 the stored idx is don't-care and must not reach out_d.
- Simultaneous push and pop: level unchanged and both pointers advance. This is legal at any non-full level; at level 0 only the push occurs.
- Reset (any time, including mid-burst):
  - level=0, pointers=0.
  - out_valid=0, out_d=0, in_ready=1.
  - Storage contents are not reset and are don't-care.

## Timing
- Latency: a code pushed at edge t into an empty FIFO shows out_valid=1 with the decoded out_d from just after edge t, i.e. visible in cycle t+1.
- Throughput: one push and one pop per cycle sustained.
- out_d is a combinational decode of a registered storage entry. It has no dependency on in_* or out_ready within a cycle.
- level, in_ready and out_valid change only on clock edges or on asynchronous reset assertion.
- Reset deassertion must be synchronised externally. The first push is possible at the first edge after rst_n rises.

## Configuration
- ONEHOT_DEC_STATS_EN defined:
  - Adds output hit_cnt, 8*2**IDX_W bits: one 8-bit saturating counter per line, packed with line i in bits [8i+7:8i].
  - Adds output zero_cnt, 8 bits.
  - On each pop, the counter for the popped entry's line increments; zero_cnt increments instead when nz=0.
  - Counters saturate at 255 and reset to 0.
- ONEHOT_DEC_STATS_EN undefined: these ports and all counter logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package onehot_dec_pkg holds:
  - the entry typedef, a packed struct {logic nz; logic [IDX_W-1:0] idx}, with IDX_W supplied as a package localparam default of 2;
  - the function onehot_decode(entry), returning the 2**IDX_W-bit vector;
  - the localparam STAT_W = 8.
- One sub-module, onehot_dec_fifo: the generic pointer/level FIFO with registered in_ready/out_valid.
- The top level instantiates the FIFO, applies onehot_decode to its head, and holds the optional statistics.

## Test plan
- Reset, then a single push of idx=2, nz=1 with out_ready=0:
  - one cycle later out_valid=1, out_d=4'b0100, level=1;
  - assert out_ready for one cycle, then out_valid=0, out_d=0.
- Push idx=3 nz=1, idx=1 nz=1, then idx=0 nz=0:
  - pops in order yield 4'b1000, 4'b0010, 4'b0000, each with out_valid=1.
- Fill with 4 pushes while out_ready=0:
  - in_ready=0 and level=4;
  - a further in_valid is not accepted;
  - one pop, then in_ready=1 on the next cycle.
- Continuous push and pop, with in_valid=out_ready=1 for 20 cycles of codes cycling idx 0..3:
  - level stays 1, pointers wrap, and the output sequence matches the input sequence with 1-cycle lag.
- Assert rst_n=0 mid-burst at level=3:
  - out_valid=0, out_d=0, in_ready=1 immediately;
  - after release, no stale entries appear.
- With ONEHOT_DEC_STATS_EN defined:
  - 300 pops of idx=1 give hit_cnt line1=255;
  - 2 pops with nz=0 give zero_cnt=2;
  - the other lines stay 0.
